// File: rtl/stopwatch_adjust_if.sv
// Digit-load write channel between the adjust writer and the stopwatch counter.
interface stopwatch_adjust_if;
   logic       wr_valid;
   logic [1:0] wr_sel;
   logic [3:0] wr_data;
   logic       wr_ready;

   modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);
endinterface

// File: rtl/stopwatch_adjust.sv
// Adjust-mode writer: synchronizes the slide switches, writes one clamped BCD
// digit per adjust tick into the counter load port (valid/ready), and drives
// the blink mask of the digit being edited.
// Optional feature: define STOPWATCH_ADJUST_BLINK_EN to build the blink
// counter; otherwise blink_mask is tied to zero.
module stopwatch_adjust #(
   parameter int SYNC_STAGES = 2,
   parameter int BLINK_TICKS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      adj_sw,
   input  logic [1:0]                sel_sw,
   input  logic [3:0]                num_sw,
   input  logic                      tick,
   stopwatch_adjust_if.master        wr,
   output logic [3:0]                blink_mask,
   output logic                      adj_active
);

   typedef enum logic [1:0] {IDLE, ARMED, WRITE} state_t;

   // Switch bundle: {adj, sel[1:0], num[3:0]}; index 0 is the newest stage
   logic [SYNC_STAGES-1:0][6:0] sync_q;
   logic       adj_s;
   logic [1:0] sel_s;
   logic [3:0] num_s;

   state_t     state_q;
   logic       first_pending_q;
   logic [1:0] last_sel_q;
   logic [3:0] last_data_q;
   logic       wr_valid_q;
   logic [1:0] wr_sel_q;
   logic [3:0] wr_data_q;
   logic       adj_active_q;

   logic [3:0] cand_data;
   logic       cand_new;

   // Seconds-tens digit tops out at 5, every other digit at 9
   function automatic logic [3:0] clamp(input logic [1:0] s, input logic [3:0] n);
      if (s == 2'd1) return (n > 4'd5) ? 4'd5 : n;
      return (n > 4'd9) ? 4'd9 : n;
   endfunction

   // Shift all raw switches through the synchronizer chain together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], {adj_sw, sel_sw, num_sw}};
   end

   assign adj_s = sync_q[SYNC_STAGES-1][6];
   assign sel_s = sync_q[SYNC_STAGES-1][5:4];
   assign num_s = sync_q[SYNC_STAGES-1][3:0];

   assign cand_data = clamp(sel_s, num_s);
   assign cand_new  = first_pending_q || (sel_s != last_sel_q) || (cand_data != last_data_q);

   // Write FSM with registered handshake outputs; leaving adjust mode has
   // priority over a coincident tick in ARMED, but never aborts a WRITE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         first_pending_q <= 1'b0;
         last_sel_q      <= '0;
         last_data_q     <= '0;
         wr_valid_q      <= 1'b0;
         wr_sel_q        <= '0;
         wr_data_q       <= '0;
         adj_active_q    <= 1'b0;
      end else begin
         adj_active_q <= adj_s;
         case (state_q)
            IDLE: begin
               wr_valid_q <= 1'b0;
               if (adj_s) begin
                  state_q         <= ARMED;
                  first_pending_q <= 1'b1;
               end
            end
            ARMED: begin
               if (!adj_s) begin
                  state_q <= IDLE;
               end else if (tick && cand_new) begin
                  state_q    <= WRITE;
                  wr_valid_q <= 1'b1;
                  wr_sel_q   <= sel_s;
                  wr_data_q  <= cand_data;
               end
            end
            WRITE: begin
               // Ticks here are dropped; outputs hold until the counter takes them
               if (wr.wr_ready) begin
                  wr_valid_q      <= 1'b0;
                  last_sel_q      <= wr_sel_q;
                  last_data_q     <= wr_data_q;
                  first_pending_q <= 1'b0;
                  state_q         <= adj_s ? ARMED : IDLE;
               end
            end
            default: begin
               state_q    <= IDLE;
               wr_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign wr.wr_valid = wr_valid_q;
   assign wr.wr_sel   = wr_sel_q;
   assign wr.wr_data  = wr_data_q;
   assign adj_active  = adj_active_q;

`ifdef STOPWATCH_ADJUST_BLINK_EN
   localparam int CW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   logic [CW-1:0] blink_cnt_q;
   logic          blink_phase_q;

   // Count adjust ticks; phase flips every BLINK_TICKS ticks, cleared outside adjust
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (!adj_s) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (tick) begin
         if (blink_cnt_q == CW'(BLINK_TICKS - 1)) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   assign blink_mask = (blink_phase_q && adj_s) ? (4'b0001 << sel_s) : 4'b0000;
`else
   assign blink_mask = 4'b0000;
`endif

endmodule

// File: tb/tb_stopwatch_adjust.sv
// Directed bench for stopwatch_adjust: vector table for write/clamp/dedup,
// plus sequences for backpressure, async reset mid-write and blink.
module tb_stopwatch_adjust;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       adj_sw;
   logic [1:0] sel_sw;
   logic [3:0] num_sw;
   logic       tick;
   logic [3:0] blink_mask;
   logic       adj_active;

   stopwatch_adjust_if wr_if ();

   stopwatch_adjust #(.SYNC_STAGES(2), .BLINK_TICKS(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .adj_sw     (adj_sw),
      .sel_sw     (sel_sw),
      .num_sw     (num_sw),
      .tick       (tick),
      .wr         (wr_if),
      .blink_mask (blink_mask),
      .adj_active (adj_active)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] sel;
      logic [3:0] num;
      logic       exp_w;
      logic [1:0] exp_sel;
      logic [3:0] exp_data;
   } vec_t;

   vec_t vecs[17];
   logic [1:0] exp_sel;
   logic [3:0] exp_data;

`ifdef STOPWATCH_ADJUST_BLINK_EN
   localparam logic [3:0] MASK3 = 4'b1000;
`else
   localparam logic [3:0] MASK3 = 4'b0000;
`endif

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_pulse();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic chk_wr(input string name, input logic v, input logic [1:0] s, input logic [3:0] d);
      chk({name, ".valid"}, 8'(wr_if.wr_valid), 8'(v));
      chk({name, ".sel"},   8'(wr_if.wr_sel),   8'(s));
      chk({name, ".data"},  8'(wr_if.wr_data),  8'(d));
   endtask

   initial begin
      //          sel   num    w     sel   data
      vecs[0]  = '{2'd2, 4'd7,  1'b1, 2'd2, 4'd7};
      vecs[1]  = '{2'd2, 4'd7,  1'b0, 2'd2, 4'd7};
      vecs[2]  = '{2'd1, 4'd9,  1'b1, 2'd1, 4'd5};
      vecs[3]  = '{2'd1, 4'd9,  1'b0, 2'd1, 4'd5};
      vecs[4]  = '{2'd1, 4'd6,  1'b0, 2'd1, 4'd5};
      vecs[5]  = '{2'd0, 4'd15, 1'b1, 2'd0, 4'd9};
      vecs[6]  = '{2'd0, 4'd3,  1'b1, 2'd0, 4'd3};
      vecs[7]  = '{2'd0, 4'd3,  1'b0, 2'd0, 4'd3};
      vecs[8]  = '{2'd0, 4'd3,  1'b0, 2'd0, 4'd3};
      vecs[9]  = '{2'd0, 4'd3,  1'b0, 2'd0, 4'd3};
      vecs[10] = '{2'd0, 4'd3,  1'b0, 2'd0, 4'd3};
      vecs[11] = '{2'd0, 4'd4,  1'b1, 2'd0, 4'd4};
      vecs[12] = '{2'd3, 4'd10, 1'b1, 2'd3, 4'd9};
      vecs[13] = '{2'd3, 4'd9,  1'b0, 2'd3, 4'd9};
      vecs[14] = '{2'd2, 4'd9,  1'b1, 2'd2, 4'd9};
      vecs[15] = '{2'd1, 4'd5,  1'b1, 2'd1, 4'd5};
      vecs[16] = '{2'd1, 4'd0,  1'b1, 2'd1, 4'd0};

      rst_n = 1'b0; adj_sw = 1'b0; sel_sw = '0; num_sw = '0; tick = 1'b0;
      wr_if.wr_ready = 1'b1;
      step(); step();
      chk_wr("reset", 1'b0, 2'd0, 4'd0);
      chk("reset.adj_active", 8'(adj_active), 8'd0);
      chk("reset.blink_mask", 8'(blink_mask), 8'd0);
      rst_n = 1'b1;
      step();

      // Synchronizer depth: adj_active rises on the third edge
      adj_sw = 1'b1; sel_sw = 2'd2; num_sw = 4'd7;
      step(); step();
      chk("sync.adj_active_early", 8'(adj_active), 8'd0);
      step();
      chk("sync.adj_active", 8'(adj_active), 8'd1);

      // Table: one tick per record, ready held high
      exp_sel = '0; exp_data = '0;
      for (int i = 0; i < 17; i++) begin
         sel_sw = vecs[i].sel; num_sw = vecs[i].num;
         repeat (3) step();
         tick_pulse();
         if (vecs[i].exp_w) begin
            exp_sel = vecs[i].exp_sel; exp_data = vecs[i].exp_data;
         end
         chk_wr($sformatf("vec%0d", i), vecs[i].exp_w, exp_sel, exp_data);
         step();
         chk($sformatf("vec%0d.valid_drop", i), 8'(wr_if.wr_valid), 8'd0);
      end

      // Backpressure: stable outputs, extra ticks dropped, adj drop does not abort
      wr_if.wr_ready = 1'b0;
      sel_sw = 2'd2; num_sw = 4'd1;
      repeat (3) step();
      tick_pulse();
      chk_wr("bp.start", 1'b1, 2'd2, 4'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) num_sw = 4'd8;
         if (i == 5 || i == 8) tick = 1'b1;
         step();
         tick = 1'b0;
         chk_wr($sformatf("bp.hold%0d", i), 1'b1, 2'd2, 4'd1);
      end
      adj_sw = 1'b0;
      repeat (3) step();
      chk_wr("bp.adj_low_hold", 1'b1, 2'd2, 4'd1);
      wr_if.wr_ready = 1'b1;
      step();
      chk("bp.done", 8'(wr_if.wr_valid), 8'd0);
      step();
      chk("bp.idle_valid", 8'(wr_if.wr_valid), 8'd0);
      chk("bp.adj_active", 8'(adj_active), 8'd0);
      tick_pulse();
      chk("bp.idle_tick", 8'(wr_if.wr_valid), 8'd0);
      // Re-entering adjust: first tick writes even though pair equals last
      adj_sw = 1'b1; num_sw = 4'd1;
      repeat (4) step();
      tick_pulse();
      chk_wr("reenter.first", 1'b1, 2'd2, 4'd1);
      step();
      chk("reenter.drop", 8'(wr_if.wr_valid), 8'd0);

      // Async reset in the middle of WRITE
      wr_if.wr_ready = 1'b0;
      sel_sw = 2'd3; num_sw = 4'd2;
      repeat (3) step();
      tick_pulse();
      chk_wr("rst.pending", 1'b1, 2'd3, 4'd2);
      #2 rst_n = 1'b0;
      #1;
      chk_wr("rst.async", 1'b0, 2'd0, 4'd0);
      chk("rst.adj_active", 8'(adj_active), 8'd0);
      chk("rst.blink_mask", 8'(blink_mask), 8'd0);
      step();
      rst_n = 1'b1;
      wr_if.wr_ready = 1'b1;
      repeat (4) step();
      tick_pulse();
      chk_wr("rst.rewrite", 1'b1, 2'd3, 4'd2);
      step();
      chk("rst.rewrite_drop", 8'(wr_if.wr_valid), 8'd0);

      // Blink sequence from a clean reset, sel 3
      rst_n = 1'b0; step(); rst_n = 1'b1;
      adj_sw = 1'b1; sel_sw = 2'd3; num_sw = 4'd0;
      repeat (4) step();
      chk("blink.init", 8'(blink_mask), 8'd0);
      tick_pulse();
      chk("blink.t1", 8'(blink_mask), 8'd0);
      step(); step();
      tick_pulse();
      chk("blink.t2", 8'(blink_mask), 8'(MASK3));
      step(); step();
      chk("blink.t2_hold", 8'(blink_mask), 8'(MASK3));
      tick_pulse();
      chk("blink.t3", 8'(blink_mask), 8'(MASK3));
      step(); step();
      tick_pulse();
      chk("blink.t4", 8'(blink_mask), 8'd0);
      step(); step();
      tick_pulse(); step(); step();
      tick_pulse();
      chk("blink.t6", 8'(blink_mask), 8'(MASK3));
      adj_sw = 1'b0;
      repeat (3) step();
      chk("blink.adj_off", 8'(blink_mask), 8'd0);
      tick_pulse(); step(); step();
      tick_pulse();
      chk("blink.adj_off_ticks", 8'(blink_mask), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
